logic_gate_pipe: RTL and testbench

//  Parametrised, pipelined N-input bitwise logic gate with a run-time selectable operation.

---
 rtl/logic_gate_pipe.sv | 74 +++++++
 tb/tb_logic_gate_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage N-input bitwise gate (AND/OR/XOR/NAND) with valid/ready flow control
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [1:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_all_ones,
  output logic [CNT_W-1:0]        out_count
);
  logic                    s1_valid;
  logic [NUM_IN*WIDTH-1:0] s1_data;
  logic [1:0]              s1_op;
  logic [WIDTH-1:0]        red_and, red_or, red_xor, res;
  logic                    s2_adv, accept;
  assign s2_adv   = s1_valid & (!out_valid | out_ready);
  assign in_ready = !s1_valid | s2_adv;
  assign accept   = in_valid & in_ready;
  // Reduce the held operands and pick the result for the captured op
  always_comb begin
    red_and = s1_data[WIDTH-1:0];
    red_or  = s1_data[WIDTH-1:0];
    red_xor = s1_data[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      red_and = red_and & s1_data[k*WIDTH +: WIDTH];
      red_or  = red_or  | s1_data[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ s1_data[k*WIDTH +: WIDTH];
    end
    res = s1_op == 2'b00 ? red_and :
          s1_op == 2'b01 ? red_or  :
          s1_op == 2'b10 ? red_xor : ~red_and;
  end
  // Stage 1: capture operands and op on accept, empty when moved on with no refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_op    <= 2'b00;
    end else begin
      s1_valid <= accept | (s1_valid & !s2_adv);
      if (accept) begin
        s1_data <= in_data;
        s1_op   <= in_op;
      end
    end
  end
  // Stage 2: register result; output holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_all_ones <= 1'b0;
    end else begin
      out_valid <= s2_adv | (out_valid & !out_ready);
      if (s2_adv) begin
        out_data     <= res;
        out_all_ones <= &res;
      end
    end
  end
  // Count results taken downstream; wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_count <= '0;
    else if (out_valid & out_ready) out_count <= out_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: scoreboard bench for logic_gate_pipe in a 2-input and a 3-input configuration
module tb_logic_gate_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        va = 1'b0, rdy_a, ov_a, oready_a = 1'b1, oa_a;
  logic [15:0] da = '0, cnt_a;
  logic [1:0]  opa = '0, opb = '0;
  logic [7:0]  od_a, od_b;
  logic        vb = 1'b0, rdy_b, ov_b, oready_b = 1'b1, oa_b;
  logic [23:0] db = '0;
  logic [3:0]  cnt_b;
  logic [8:0]  qa[$], qb[$];
  int          checks = 0, errors = 0, hs_a = 0, hs_b = 0, acc_a = 0;
  logic        rand_en = 1'b0, wait_a = 1'b0;

  logic_gate_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(rdy_a), .in_data(da), .in_op(opa),
    .out_valid(ov_a), .out_ready(oready_a), .out_data(od_a), .out_all_ones(oa_a), .out_count(cnt_a));
  logic_gate_pipe #(.WIDTH(8), .NUM_IN(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rdy_b), .in_data(db), .in_op(opb),
    .out_valid(ov_b), .out_ready(oready_b), .out_data(od_b), .out_all_ones(oa_b), .out_count(cnt_b));

  always #5 clk = ~clk;

  // Reference: per result bit, count how many operands have it set and apply the gate rule
  function automatic logic [8:0] model(input logic [23:0] d, input int n, input logic [1:0] op);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) begin
      int ones = 0;
      for (int k = 0; k < n; k++) ones += int'(d[k*8+b]);
      case (op)
        2'd0: r[b] = (ones == n);
        2'd1: r[b] = (ones > 0);
        2'd2: r[b] = (ones % 2 == 1);
        default: r[b] = (ones != n);
      endcase
    end
    return {r == 8'hFF, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard A: push on accept, pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      hs_a = 0;
    end else begin
      assert (!(wait_a && !va)) else $error("in_valid withdrawn while waiting");
      wait_a = va && !rdy_a;
      if (va && rdy_a) begin
        qa.push_back(model({8'h00, da}, 2, opa));
        acc_a++;
      end
      if (ov_a && oready_a) begin
        if (qa.size() == 0) chk("a_unexpected_output", {23'd0, oa_a, od_a}, 32'hDEAD);
        else chk("a_result", {23'd0, oa_a, od_a}, {23'd0, qa.pop_front()});
        chk("a_count", cnt_a, hs_a[15:0]);
        hs_a++;
      end
    end
  end

  // Scoreboard B (3 inputs, 4-bit wrapping counter)
  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete();
      hs_b = 0;
    end else begin
      if (vb && rdy_b) qb.push_back(model(db, 3, opb));
      if (ov_b && oready_b) begin
        if (qb.size() == 0) chk("b_unexpected_output", {23'd0, oa_b, od_b}, 32'hDEAD);
        else chk("b_result", {23'd0, oa_b, od_b}, {23'd0, qb.pop_front()});
        chk("b_count", cnt_b, hs_b % 16);
        hs_b++;
      end
    end
  end

  always @(posedge clk) if (rand_en) #1 oready_a = 1'($urandom_range(0, 1));

  task automatic send_a(input logic [15:0] d, input logic [1:0] op);
    int t = 0;
    va = 1'b1; da = d; opa = op;
    @(negedge clk);
    while (!rdy_a && t < 200) begin @(negedge clk); t++; end
    if (!rdy_a) chk("a_accept_timeout", rdy_a, 1);
    @(posedge clk); #1 va = 1'b0;
  endtask

  task automatic send_b(input logic [23:0] d, input logic [1:0] op);
    int t = 0;
    vb = 1'b1; db = d; opb = op;
    @(negedge clk);
    while (!rdy_b && t < 200) begin @(negedge clk); t++; end
    if (!rdy_b) chk("b_accept_timeout", rdy_b, 1);
    @(posedge clk); #1 vb = 1'b0;
  endtask

  task automatic drain(input int which);
    int t = 0;
    while ((which == 0 ? qa.size() : qb.size()) > 0 && t < 1000) begin @(negedge clk); t++; end
    chk(which == 0 ? "a_drain" : "b_drain", which == 0 ? qa.size() : qb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] exp_ops [4];
    logic [7:0] held;
    exp_ops = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", ov_a, 0);
    chk("reset_out_data", od_a, 0);
    chk("reset_all_ones", oa_a, 0);
    chk("reset_count", cnt_a, 0);
    chk("reset_in_ready", rdy_a, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // Each op on 0xF0, 0x3C; result lands two cycles after accept
    for (int i = 0; i < 4; i++) begin
      send_a(16'h3CF0, 2'(i));
      @(negedge clk);
      chk("op_latency_early", ov_a, 0);
      @(negedge clk);
      chk("op_latency_valid", ov_a, 1);
      chk("op_value", od_a, exp_ops[i]);
      @(posedge clk); #1;
    end
    // Backpressure: 5 beats, downstream stalled for 4 cycles
    oready_a = 1'b0;
    begin
      int base;
      base = acc_a;
      fork
        for (int i = 0; i < 5; i++) send_a(16'($urandom), 2'($urandom_range(0, 3)));
        begin
          @(negedge clk); @(negedge clk); @(negedge clk);
          held = od_a;
          chk("bp_valid", ov_a, 1);
          @(negedge clk);
          @(negedge clk);
          chk("bp_in_ready_low", rdy_a, 0);
          chk("bp_two_accepts", acc_a - base, 2);
          chk("bp_data_hold", od_a, held);
          chk("bp_valid_hold", ov_a, 1);
          @(posedge clk); #1 oready_a = 1'b1;
        end
      join
    end
    drain(0);
    // Reset with two beats in flight: they must never appear
    send_a(16'h1234, 2'd1);
    send_a(16'h5678, 2'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", ov_a, 0);
    chk("midreset_count", cnt_a, 0);
    chk("midreset_in_ready", rdy_a, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    // 100 random beats with random downstream readiness
    rand_en = 1'b1;
    for (int i = 0; i < 100; i++) send_a(16'($urandom), 2'($urandom_range(0, 3)));
    drain(0);
    rand_en = 1'b0;
    #2 oready_a = 1'b1;
    @(negedge clk);
    chk("stream_count", cnt_a, 100);
    @(posedge clk); #1;
    // Three-input AND/XOR of all-ones operands
    send_b(24'hFFFFFF, 2'd0);
    @(negedge clk); @(negedge clk);
    chk("n3_and_data", od_b, 8'hFF);
    chk("n3_and_ones", oa_b, 1);
    @(posedge clk); #1;
    send_b(24'hFFFFFF, 2'd2);
    @(negedge clk); @(negedge clk);
    chk("n3_xor_data", od_b, 8'hFF);
    chk("n3_xor_ones", oa_b, 1);
    @(posedge clk); #1;
    // 15 more results to reach 17: 4-bit counter wraps through 0 to 1
    for (int i = 0; i < 15; i++) send_b(24'($urandom), 2'($urandom_range(0, 3)));
    drain(1);
    @(negedge clk);
    chk("wrap_count", cnt_b, 1);
    chk("wrap_handshakes", hs_b, 17);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
